// File: rtl/eth_rgmii_frame_tx_if.sv
// ---------------------------------------------------------------------------
// eth_rgmii_frame_tx_if
// Purpose : Connects the frame transmitter to the per-channel capture buffers.
//           A channel raises req and presents len. The transmitter answers with
//           a one-cycle ack and then reads the payload through rd_ad/rd_data.
//           The buffer RAM has one cycle of read latency.
// Signals : req     [NCH]         per-channel level request (buffer ready)
//           len     [NCH*11]      per-channel payload byte count, slice i = ch i
//           ack     [NCH]         one-cycle grant pulse
//           rd_ad   [RD_W]        read address {channel, offset}
//           rd_data [8]           read data, valid one cycle after rd_ad
// Modports: master = frame transmitter, slave = capture buffers.
// ---------------------------------------------------------------------------
interface eth_rgmii_frame_tx_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 10
);
    localparam int RD_W = $clog2(NCH) + ADDR_W;

    logic [NCH-1:0]    req;
    logic [NCH*11-1:0] len;
    logic [NCH-1:0]    ack;
    logic [RD_W-1:0]   rd_ad;
    logic [7:0]        rd_data;

    modport master (
        input  req,
        input  len,
        input  rd_data,
        output ack,
        output rd_ad
    );

    modport slave (
        output req,
        output len,
        output rd_data,
        input  ack,
        input  rd_ad
    );
endinterface

// File: rtl/eth_rgmii_frame_tx.sv
// ---------------------------------------------------------------------------
// eth_rgmii_frame_tx
// Purpose : Multi-channel, variable-length Ethernet II frame generator that
//           drives an RGMII transmit port at 125 MHz. Channels are served
//           round-robin. Each frame carries a 16-bit per-channel sequence
//           number after the EtherType. Short payloads are zero-padded to the
//           64-byte minimum frame. The frame ends with a CRC-32 FCS and is
//           followed by an enforced inter-frame gap.
// Ports   : clk125   in   125 MHz clock
//           rst_n    in   asynchronous active-low reset
//           buf_if   ifc  capture-buffer side (req/len/ack/rd_ad/rd_data)
//           busy_o   out  high from the cycle after grant through the end of IFG
//           done_o   out  one-cycle pulse in the first IFG cycle
//           txctl_o  out  RGMII TX_CTL (TX_EN on both edges, TX_ER = 0)
//           txd_o    out  RGMII TXD, low nibble while clk125 is high,
//                         high nibble while clk125 is low
// ---------------------------------------------------------------------------
module eth_rgmii_frame_tx #(
    parameter int          NCH         = 2,
    parameter int          ADDR_W      = 10,
    parameter int          PAYLOAD_MAX = 1024,
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0000_88DA_B8BF,
    parameter logic [15:0] ETYPE       = 16'h1919,
    parameter int          IFG_BYTES   = 12
) (
    input  logic                 clk125,
    input  logic                 rst_n,
    eth_rgmii_frame_tx_if.master buf_if,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 txctl_o,
    output logic [3:0]           txd_o
);

    localparam int                CH_W        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int                LEN_W       = 11;
    localparam logic [LEN_W-1:0]  LEN_CAP     = LEN_W'(PAYLOAD_MAX);
    localparam logic [LEN_W-1:0]  MIN_PAYLOAD = 11'd44;
    // The IDLE cycle that grants the next channel is counted toward the gap.
    // So IFG itself lasts one cycle less than IFG_BYTES, and a held req
    // still gives exactly IFG_BYTES quiet cycles between frames.
    localparam logic [LEN_W-1:0]  IFG_LAST    = LEN_W'(IFG_BYTES - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;       // byte index within the current state
    logic [CH_W-1:0]   ch_q, ch_d;         // channel owning the current frame
    logic [CH_W-1:0]   ptr_q, ptr_d;       // round-robin search start
    logic [LEN_W-1:0]  n_q, n_d;           // latched (clamped) payload length
    logic [LEN_W-1:0]  fetch_q, fetch_d;   // buffer read offset
    logic [7:0]        txd_q, txd_d;       // byte currently on the pins
    logic              txen_q, txen_d;
    logic [31:0]       crc_q, crc_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [15:0]       seq_q [NCH];
    logic [15:0]       seq_d [NCH];

    logic              arb_found;
    logic [CH_W-1:0]   arb_idx;
    logic [LEN_W-1:0]  len_sel;
    logic [31:0]       fcs;

    // Reflected CRC-32 (poly 0xEDB88320), one byte per call, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    // Channel index 'off' places after 'base', wrapping at NCH.
    function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base,
                                                 input int              off);
        int k;
        k = int'(base) + off;
        if (k >= NCH) k = k - NCH;
        return CH_W'(k);
    endfunction

    // ------------------------------------------------------------------
    // Round-robin arbiter: first requesting channel at or after ptr_q.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!arb_found && buf_if.req[rr_index(ptr_q, i)]) begin
                arb_found = 1'b1;
                arb_idx   = rr_index(ptr_q, i);
            end
        end
    end

    assign len_sel    = buf_if.len[arb_idx*LEN_W +: LEN_W];
    // The grant is combinational so that the preamble starts the very next cycle.
    assign buf_if.ack = (state_q == S_IDLE && arb_found) ? (NCH'(1) << arb_idx) : '0;

    // ------------------------------------------------------------------
    // Next state, counters and the byte to put on the pins next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        n_d     = n_q;
        fetch_d = fetch_q;
        seq_d   = seq_q;
        txd_d   = 8'h00;
        crc_d   = crc_q;
        fcs     = ~crc_q;

        unique case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                    ch_d    = arb_idx;
                    ptr_d   = (arb_idx == CH_W'(NCH - 1)) ? '0 : arb_idx + 1'b1;
                    n_d     = (len_sel > LEN_CAP) ? LEN_CAP : len_sel;
                end
            end
            S_PRE: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == 11'd7) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
                end
            end
            S_HDR: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == 11'd15) begin
                    state_d = (n_q == '0) ? S_PAD : S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == n_q - 11'd1) begin
                    // PAD keeps counting from N so it always ends at byte 43.
                    if (n_q < MIN_PAYLOAD) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FCS;
                        cnt_d   = '0;
                    end
                end
            end
            S_PAD: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == MIN_PAYLOAD - 11'd1) begin
                    state_d = S_FCS;
                    cnt_d   = '0;
                end
            end
            S_FCS: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == 11'd0) seq_d[ch_q] = seq_q[ch_q] + 16'd1;
                if (cnt_q == 11'd3) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end
            end
            S_IFG: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The buffer RAM answers one cycle after the address, and the answer
        // is registered into txd_q one more cycle later. So offset 0 goes out
        // two cycles before DATA byte 0, during header byte 14.
        if (state_q == S_HDR && cnt_q == 11'd13) begin
            fetch_d = '0;
        end else if (((state_q == S_HDR && cnt_q >= 11'd14) || state_q == S_DATA) &&
                     (fetch_q + 11'd1 < n_q)) begin
            fetch_d = fetch_q + 11'd1;
        end

        // Byte for the next cycle, chosen from the next state.
        unique case (state_d)
            S_PRE:  txd_d = (cnt_d == 11'd7) ? 8'hD5 : 8'h55;
            S_HDR: begin
                unique case (cnt_d[3:0])
                    4'd0:  txd_d = DST_MAC[47:40];
                    4'd1:  txd_d = DST_MAC[39:32];
                    4'd2:  txd_d = DST_MAC[31:24];
                    4'd3:  txd_d = DST_MAC[23:16];
                    4'd4:  txd_d = DST_MAC[15:8];
                    4'd5:  txd_d = DST_MAC[7:0];
                    4'd6:  txd_d = SRC_MAC[47:40];
                    4'd7:  txd_d = SRC_MAC[39:32];
                    4'd8:  txd_d = SRC_MAC[31:24];
                    4'd9:  txd_d = SRC_MAC[23:16];
                    4'd10: txd_d = SRC_MAC[15:8];
                    4'd11: txd_d = SRC_MAC[7:0];
                    4'd12: txd_d = ETYPE[15:8];
                    4'd13: txd_d = ETYPE[7:0];
                    4'd14: txd_d = seq_q[ch_q][7:0];
                    default: txd_d = seq_q[ch_q][15:8];
                endcase
            end
            S_DATA: txd_d = buf_if.rd_data;
            S_FCS: begin
                unique case (cnt_d[1:0])
                    2'd0:    txd_d = fcs[7:0];
                    2'd1:    txd_d = fcs[15:8];
                    2'd2:    txd_d = fcs[23:16];
                    default: txd_d = fcs[31:24];
                endcase
            end
            default: txd_d = 8'h00;
        endcase

        // The CRC covers exactly the bytes sent from DST through PAD.
        if (state_d == S_PRE) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (state_d == S_HDR || state_d == S_DATA || state_d == S_PAD) begin
            crc_d = crc32_byte(crc_q, txd_d);
        end
    end

    assign txen_d = (state_d == S_PRE) || (state_d == S_HDR) || (state_d == S_DATA) ||
                    (state_d == S_PAD) || (state_d == S_FCS);
    assign busy_d = (state_d != S_IDLE);
    assign done_d = (state_q == S_FCS) && (state_d == S_IFG);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            n_q     <= '0;
            fetch_q <= '0;
            txd_q   <= 8'h00;
            txen_q  <= 1'b0;
            crc_q   <= 32'hFFFF_FFFF;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            // NOTE: the sequence table is small and must be cleared by reset, so it is flops, not a RAM.
            for (int i = 0; i < NCH; i++) seq_q[i] <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            n_q     <= n_d;
            fetch_q <= fetch_d;
            txd_q   <= txd_d;
            txen_q  <= txen_d;
            crc_q   <= crc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            seq_q   <= seq_d;
        end
    end

    generate
        if (NCH > 1) begin : g_rd_multi
            assign buf_if.rd_ad = {ch_q, ADDR_W'(fetch_q)};
        end else begin : g_rd_single
            assign buf_if.rd_ad = ADDR_W'(fetch_q);
        end
    endgenerate

    assign txctl_o = txen_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    // Behavioural DDR output. A device-specific ODDR replaces this mux in a real pin mapping.
    assign txd_o   = clk125 ? txd_q[3:0] : txd_q[7:4];

endmodule

// File: tb/tb_eth_rgmii_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_eth_rgmii_frame_tx
// Bench for eth_rgmii_frame_tx. It applies a table of single-frame requests,
// then a back-to-back sequence with req held, then a reset in mid-frame.
// A monitor rebuilds bytes from the DDR pins.
// Expected frames come from a reference byte builder and a CRC residue check.
// ---------------------------------------------------------------------------
module tb_eth_rgmii_frame_tx;
    localparam int NCH    = 2;
    localparam int ADDR_W = 10;

    logic       clk125 = 1'b0;
    logic       rst_n  = 1'b0;
    logic       busy, done, txctl;
    logic [3:0] txd;

    eth_rgmii_frame_tx_if #(.NCH(NCH), .ADDR_W(ADDR_W)) bif ();

    eth_rgmii_frame_tx #(.NCH(NCH), .ADDR_W(ADDR_W)) dut (
        .clk125  (clk125),
        .rst_n   (rst_n),
        .buf_if  (bif),
        .busy_o  (busy),
        .done_o  (done),
        .txctl_o (txctl),
        .txd_o   (txd)
    );

    always #4 clk125 = ~clk125;

    // Buffer contents: channel 1 differs so a wrong channel shows up in the data.
    function automatic logic [7:0] mem_byte(input logic ch, input logic [9:0] off);
        return off[7:0] ^ (ch ? 8'h5A : 8'h00);
    endfunction

    // Synchronous RAM with one cycle of read latency.
    always @(posedge clk125) bif.rd_data <= mem_byte(bif.rd_ad[10], bif.rd_ad[9:0]);

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            c = ((c[0] ^ d[b]) != 1'b0) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    typedef struct {
        logic [1:0] req;
        int         len;
        int         exp_ch;
        int         exp_cycles;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  cap_q[$];
    logic [7:0]  exp_q[$];
    int          ack_log[$];
    int          gap_q[$];
    int          en_cycles, done_cnt, done_misplaced, ack_multi, ack_bad, idle_run;
    bit          seen_tx;
    logic [15:0] exp_seq [NCH];
    vec_t        vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pin monitor: low nibble in the high phase, high nibble in the low phase.
    initial begin : monitor
        logic [3:0]     lo;
        logic           en, dn, prev_en, prev_ak;
        logic [NCH-1:0] ak;
        prev_en = 1'b0;
        prev_ak = 1'b0;
        forever begin
            @(posedge clk125);
            #2;
            lo = txd;
            en = txctl;
            dn = done;
            if (en) en_cycles++;
            if (dn) begin
                done_cnt++;
                if (!(prev_en && !en)) done_misplaced++;
            end
            if (en) begin
                if (seen_tx && idle_run > 0) gap_q.push_back(idle_run);
                idle_run = 0;
                seen_tx  = 1'b1;
            end else if (seen_tx) begin
                idle_run++;
            end
            prev_en = en;
            @(negedge clk125);
            #2;
            if (en) cap_q.push_back({txd, lo});
            ak = bif.ack;
            if (ak != '0) begin
                if ($onehot(ak)) begin
                    for (int i = 0; i < NCH; i++) if (ak[i]) ack_log.push_back(i);
                end else begin
                    ack_bad++;
                end
                if (prev_ak) ack_multi++;
            end
            prev_ak = (ak != '0);
        end
    end

    task automatic reset_counts();
        cap_q.delete();
        exp_q.delete();
        ack_log.delete();
        gap_q.delete();
        en_cycles      = 0;
        done_cnt       = 0;
        done_misplaced = 0;
        ack_multi      = 0;
        ack_bad        = 0;
        idle_run       = 0;
        seen_tx        = 1'b0;
    endtask

    // Reference frame: preamble, header, payload, pad, FCS appended to exp_q.
    task automatic add_frame(input int ch, input int len, input logic [15:0] seq);
        int          n, start;
        logic [31:0] c;
        logic [47:0] dst, src;
        dst = 48'hFFFF_FFFF_FFFF;
        src = 48'h0000_88DA_B8BF;
        n   = (len > 1024) ? 1024 : len;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        start = exp_q.size();
        for (int i = 0; i < 6; i++) exp_q.push_back(dst[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) exp_q.push_back(src[47 - 8*i -: 8]);
        exp_q.push_back(8'h19);
        exp_q.push_back(8'h19);
        exp_q.push_back(seq[7:0]);
        exp_q.push_back(seq[15:8]);
        for (int i = 0; i < n; i++) exp_q.push_back(mem_byte(ch[0], 10'(i)));
        for (int i = n; i < 44; i++) exp_q.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = start; i < exp_q.size(); i++) c = crc_upd(c, exp_q[i]);
        c = ~c;
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[23:16]);
        exp_q.push_back(c[31:24]);
    endtask

    task automatic cmp_stream(input string name);
        int bad;
        int lim;
        bad = 0;
        check({name, "_nbytes"}, cap_q.size(), exp_q.size());
        lim = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) if (cap_q[i] !== exp_q[i]) bad++;
        check({name, "_bytes_wrong"}, bad, 0);
    endtask

    // CRC over DST..FCS of one captured frame must leave the fixed residue.
    task automatic check_residue(input string name);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < cap_q.size(); i++) c = crc_upd(c, cap_q[i]);
        check({name, "_fcs_residue"}, c, 32'hDEBB_20E3);
    endtask

    task automatic wait_acks(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (ack_log.size() < target && k < budget) begin
            @(posedge clk125);
            #1;
            k++;
        end
        check({name, "_ack_seen"}, (ack_log.size() >= target), 1);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(posedge clk125);
            #1;
            k++;
        end
        check({name, "_done_seen"}, (done_cnt >= target), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(posedge clk125);
            #1;
            k++;
        end
        check({name, "_busy_fall"}, busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        reset_counts();
        bif.len = {11'(v.len), 11'(v.len)};
        bif.req = v.req;
        wait_acks(1, 8, name);
        bif.req = '0;  // dropping req after ack must not disturb the frame
        wait_done(1, 1200, name);
        wait_idle(30, name);
        repeat (3) @(posedge clk125);
        #1;
        check({name, "_ack_ch"}, (ack_log.size() > 0) ? ack_log[0] : -1, v.exp_ch);
        check({name, "_ack_count"}, ack_log.size(), 1);
        check({name, "_ack_width"}, ack_multi + ack_bad, 0);
        check({name, "_txctl_cycles"}, en_cycles, v.exp_cycles);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_done_place"}, done_misplaced, 0);
        add_frame(v.exp_ch, v.len, exp_seq[v.exp_ch]);
        cmp_stream(name);
        check_residue(name);
        exp_seq[v.exp_ch]++;
    endtask

    initial begin : stimulus
        int k;
        vecs[0] = '{req: 2'b01, len: 1024, exp_ch: 0, exp_cycles: 1052};
        vecs[1] = '{req: 2'b10, len: 0,    exp_ch: 1, exp_cycles: 72};
        vecs[2] = '{req: 2'b10, len: 50,   exp_ch: 1, exp_cycles: 78};
        vecs[3] = '{req: 2'b11, len: 2000, exp_ch: 0, exp_cycles: 1052};
        vecs[4] = '{req: 2'b11, len: 5,    exp_ch: 1, exp_cycles: 72};
        vecs[5] = '{req: 2'b01, len: 43,   exp_ch: 0, exp_cycles: 72};
        vecs[6] = '{req: 2'b01, len: 44,   exp_ch: 0, exp_cycles: 72};
        vecs[7] = '{req: 2'b10, len: 1,    exp_ch: 1, exp_cycles: 72};
        for (int i = 0; i < NCH; i++) exp_seq[i] = 16'h0000;
        bif.req = '0;
        bif.len = '0;
        reset_counts();

        // Reset values.
        repeat (3) @(posedge clk125);
        #1;
        check("rst_txctl", txctl, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack", bif.ack, 0);
        check("rst_rd_ad", bif.rd_ad, 0);
        check("rst_txd_lo", txd, 0);
        @(negedge clk125);
        #1;
        check("rst_txd_hi", txd, 0);
        rst_n = 1'b1;
        @(posedge clk125);
        #1;

        // Single frames from the table.
        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: req held on both channels, pointer is back at ch0.
        reset_counts();
        bif.len = {11'd60, 11'd60};
        bif.req = 2'b11;
        wait_acks(3, 400, "b2b");
        bif.req = '0;
        wait_done(3, 400, "b2b");
        wait_idle(30, "b2b");
        repeat (3) @(posedge clk125);
        #1;
        check("b2b_ack_count", ack_log.size(), 3);
        check("b2b_grant0", (ack_log.size() > 0) ? ack_log[0] : -1, 0);
        check("b2b_grant1", (ack_log.size() > 1) ? ack_log[1] : -1, 1);
        check("b2b_grant2", (ack_log.size() > 2) ? ack_log[2] : -1, 0);
        check("b2b_ack_width", ack_multi + ack_bad, 0);
        check("b2b_gap_count", gap_q.size(), 2);
        check("b2b_gap0", (gap_q.size() > 0) ? gap_q[0] : -1, 12);
        check("b2b_gap1", (gap_q.size() > 1) ? gap_q[1] : -1, 12);
        check("b2b_txctl_cycles", en_cycles, 3 * 88);
        add_frame(0, 60, exp_seq[0]);
        add_frame(1, 60, exp_seq[1]);
        add_frame(0, 60, exp_seq[0] + 16'd1);
        cmp_stream("b2b");
        exp_seq[0] = exp_seq[0] + 16'd2;
        exp_seq[1] = exp_seq[1] + 16'd1;

        // Reset in mid-frame on ch0, then ch0 must win again with seq 0.
        reset_counts();
        bif.len = {11'd1024, 11'd1024};
        bif.req = 2'b01;
        wait_acks(1, 8, "mid");
        bif.req = '0;
        k = 0;
        while (en_cycles < 300 && k < 400) begin
            @(posedge clk125);
            #1;
            k++;
        end
        #1;
        check("mid_txctl_before", txctl, 1);
        rst_n = 1'b0;
        #1;
        check("mid_txctl_async", txctl, 0);
        check("mid_txd_async", txd, 0);
        repeat (3) @(posedge clk125);
        #1;
        check("mid_busy", busy, 0);
        check("mid_rd_ad", bif.rd_ad, 0);
        @(negedge clk125);
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) exp_seq[i] = 16'h0000;
        @(posedge clk125);
        #1;
        reset_counts();
        vecs[0] = '{req: 2'b11, len: 10, exp_ch: 0, exp_cycles: 72};
        run_vec(vecs[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
